// File: rtl/processor_fetch_ras.sv
// Fetch stage: instruction pointer plus a circular return-address stack, so a
// return resolves in a single cycle from the combinational read of stack[top].
module processor_fetch_ras #(
  parameter int                      ADDR_SIZE  = 18,
  parameter int                      RAS_DEPTH  = 8,
  parameter logic [ADDR_SIZE-1:0]    RESET_ADDR = {ADDR_SIZE{1'b0}}
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           no_operation,
  output logic [ADDR_SIZE-1:0]           code_addr,
  input  logic                           call_performed,
  input  logic [ADDR_SIZE-1:0]           ip_to_call,
  input  logic [ADDR_SIZE-1:0]           call_return_addr,
  input  logic                           return_performed,
  input  logic [ADDR_SIZE-1:0]           ip_to_return,
  input  logic                           jump_performed,
  input  logic [ADDR_SIZE-1:0]           ip_to_jump,
  output logic                           no_operation_out,
  output logic [ADDR_SIZE-1:0]           ip_out,
  output logic [ADDR_SIZE-1:0]           ip_plus_one_out,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [ADDR_SIZE-1:0] IP_ONE   = ADDR_SIZE'(1);

  logic [ADDR_SIZE-1:0] ip_q, ip_d;
  logic [PTR_W-1:0]     top_q, top_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 nop_out_q, nop_out_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic [ADDR_SIZE-1:0] stack_q [RAS_DEPTH];

  logic                 stack_we_s;
  logic [PTR_W-1:0]     stack_waddr_s;
  logic [ADDR_SIZE-1:0] stack_wdata_s;
  logic [ADDR_SIZE-1:0] stack_top_s;
  logic [ADDR_SIZE-1:0] ip_plus_one_s;
  logic                 ras_empty_s;
  logic                 ras_full_s;

  assign stack_top_s   = stack_q[top_q];
  assign ip_plus_one_s = ip_q + IP_ONE;
  assign ras_empty_s   = (count_q == CNT_ZERO);
  assign ras_full_s    = (count_q == CNT_FULL);

  assign code_addr        = ip_q;
  assign ip_out           = ip_q;
  assign ip_plus_one_out  = ip_plus_one_s;
  assign no_operation_out = nop_out_q;
  assign ras_count        = count_q;
  assign ras_overflow     = overflow_q;
  assign ras_underflow    = underflow_q;

  // Next-state: return > call > jump > sequential increment, all gated by stall.
  always_comb begin
    ip_d          = ip_q;
    top_d         = top_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;
    stack_we_s    = 1'b0;
    stack_waddr_s = top_q + PTR_ONE;
    stack_wdata_s = call_return_addr;
    nop_out_d     = no_operation | call_performed | return_performed | jump_performed;

    if (no_operation) begin
      ip_d    = ip_q;
      top_d   = top_q;
      count_d = count_q;
    end else if (return_performed) begin
      if (ras_empty_s) begin
        ip_d        = ip_to_return;
        underflow_d = 1'b1;
      end else begin
        ip_d    = stack_top_s;
        top_d   = top_q - PTR_ONE;
        count_d = count_q - CNT_ONE;
      end
    end else if (call_performed) begin
      // A full stack wraps onto its oldest entry, which sits at top+1.
      ip_d       = ip_to_call;
      top_d      = top_q + PTR_ONE;
      stack_we_s = 1'b1;
      if (ras_full_s) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end else if (jump_performed) begin
      ip_d = ip_to_jump;
    end else begin
      ip_d = ip_plus_one_s;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      ip_q        <= RESET_ADDR;
      top_q       <= {PTR_W{1'b0}};
      count_q     <= CNT_ZERO;
      nop_out_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      ip_q        <= ip_d;
      top_q       <= top_d;
      count_q     <= count_d;
      nop_out_q   <= nop_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Stack storage; contents are meaningless after reset, so it has none.
  always_ff @(posedge clock) begin
    if (stack_we_s && !reset) begin
      stack_q[stack_waddr_s] <= stack_wdata_s;
    end
  end

endmodule
